// File: rtl/phase_timer_pkg.sv
// Shared types and constants for the traffic-light phase timer.
// Default durations assume a 50 MHz clock.
package phase_timer_pkg;

    typedef enum logic {IDLE, RUN} phase_state_t;

    localparam int DUR_GREEN  = 249_999_999;
    localparam int DUR_YELLOW = 49_999_999;
    localparam int DUR_RED    = 249_999_999;

    localparam int PH_GREEN  = 0;
    localparam int PH_YELLOW = 1;
    localparam int PH_RED    = 2;

endpackage

// File: rtl/phase_timer_if.sv
// Control/status bundle between the light-sequencing FSM (master) and the timer (slave).
interface phase_timer_if #(
    parameter int CNT_W   = 28,
    parameter int N_PHASE = 3
);
    localparam int PHASE_W = $clog2(N_PHASE);

    logic               start;
    logic [PHASE_W-1:0] start_phase;
    logic               auto;
    logic               hold;
    logic               abort;
    logic               cfg_we;
    logic [PHASE_W-1:0] cfg_phase;
    logic [CNT_W-1:0]   cfg_dur;
    logic               busy;
    logic [PHASE_W-1:0] phase;
    logic [CNT_W-1:0]   remaining;
    logic               phase_done;
    logic [N_PHASE-1:0] expired;

    modport master (
        output start, start_phase, auto, hold, abort, cfg_we, cfg_phase, cfg_dur,
        input  busy, phase, remaining, phase_done, expired
    );

    modport slave (
        input  start, start_phase, auto, hold, abort, cfg_we, cfg_phase, cfg_dur,
        output busy, phase, remaining, phase_done, expired
    );

endinterface

// File: rtl/phase_dur_bank.sv
// Per-phase duration registers: one write port, one combinational read port.
// Reads see the pre-edge value, so a same-edge write never affects a load.
module phase_dur_bank
    import phase_timer_pkg::*;
#(
    parameter int               CNT_W   = 28,
    parameter int               N_PHASE = 3,
    parameter logic [CNT_W-1:0] DUR0    = CNT_W'(DUR_GREEN),
    parameter logic [CNT_W-1:0] DUR1    = CNT_W'(DUR_YELLOW),
    parameter logic [CNT_W-1:0] DUR2    = CNT_W'(DUR_RED)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we_i,
    input  logic [$clog2(N_PHASE)-1:0] waddr_i,
    input  logic [CNT_W-1:0]           wdata_i,
    input  logic [$clog2(N_PHASE)-1:0] raddr_i,
    output logic [CNT_W-1:0]           rdata_o
);

    localparam int               PHASE_W = $clog2(N_PHASE);
    localparam logic [PHASE_W:0] N_LIM   = (PHASE_W + 1)'(N_PHASE);

    logic [CNT_W-1:0] dur_q [N_PHASE];
    logic             waddr_ok;

    function automatic logic [CNT_W-1:0] reset_val(int idx);
        case (idx)
            PH_YELLOW: return DUR1;
            PH_RED:    return DUR2;
            default:   return DUR0;
        endcase
    endfunction

    assign waddr_ok = ({1'b0, waddr_i} < N_LIM);
    assign rdata_o  = dur_q[raddr_i];

    // NOTE: this small register bank is reset on purpose so durations return to defaults; large RAMs normally are not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PHASE; i++) dur_q[i] <= reset_val(i);
        end else if (we_i && waddr_ok) begin
            dur_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/phase_timer.sv
// Multi-phase countdown timer: loads a per-phase duration, counts to zero,
// pulses on expiry and optionally advances to the next phase with wrap-around.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int               CNT_W   = 28,
    parameter int               N_PHASE = 3,
    parameter logic [CNT_W-1:0] DUR0    = CNT_W'(DUR_GREEN),
    parameter logic [CNT_W-1:0] DUR1    = CNT_W'(DUR_YELLOW),
    parameter logic [CNT_W-1:0] DUR2    = CNT_W'(DUR_RED)
) (
    input  logic          clk,
    input  logic          rst_n,
    phase_timer_if.slave  bus
);

    localparam int                 PHASE_W = $clog2(N_PHASE);
    localparam logic [PHASE_W:0]   N_LIM   = (PHASE_W + 1)'(N_PHASE);
    localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(N_PHASE - 1);

    phase_state_t       state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               auto_q, auto_d;
    logic               done_q, done_d;
    logic [N_PHASE-1:0] expired_q, expired_d;

    logic               start_ok;
    logic [PHASE_W-1:0] phase_nxt;
    logic [PHASE_W-1:0] rd_addr;
    logic [CNT_W-1:0]   rd_dur;

    assign start_ok  = bus.start && ({1'b0, bus.start_phase} < N_LIM);
    assign phase_nxt = (phase_q == LAST_PH) ? '0 : phase_q + PHASE_W'(1);
    // A start load and an auto-advance load are mutually exclusive, so one read port serves both.
    assign rd_addr   = start_ok ? bus.start_phase : phase_nxt;

    phase_dur_bank #(
        .CNT_W  (CNT_W),
        .N_PHASE(N_PHASE),
        .DUR0   (DUR0),
        .DUR1   (DUR1),
        .DUR2   (DUR2)
    ) u_dur_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (bus.cfg_we),
        .waddr_i(bus.cfg_phase),
        .wdata_i(bus.cfg_dur),
        .raddr_i(rd_addr),
        .rdata_o(rd_dur)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the branches can infer a latch.
        state_d   = state_q;
        phase_d   = phase_q;
        rem_d     = rem_q;
        auto_d    = auto_q;
        done_d    = 1'b0;
        expired_d = '0;

        if (bus.abort) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (start_ok) begin
            state_d = RUN;
            phase_d = bus.start_phase;
            rem_d   = rd_dur;
            auto_d  = bus.auto;
        end else if (state_q == RUN && !bus.hold) begin
            if (rem_q != '0) begin
                rem_d = rem_q - CNT_W'(1);
            end else begin
                done_d    = 1'b1;
                expired_d = N_PHASE'(1) << phase_q;
                if (auto_q) begin
                    phase_d = phase_nxt;
                    rem_d   = rd_dur;
                end else begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            rem_q     <= '0;
            auto_q    <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            rem_q     <= rem_d;
            auto_q    <= auto_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.phase      = phase_q;
    assign bus.remaining  = rem_q;
    assign bus.phase_done = done_q;
    assign bus.expired    = expired_q;

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: a phase-length reference model predicts every
// cycle's outputs and expiry events; a monitor compares them against the DUT.
module tb_phase_timer;
    import phase_timer_pkg::*;

    localparam int CW = 8;
    localparam int NP = 3;
    localparam int D0 = 4;
    localparam int D1 = 1;
    localparam int D2 = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    phase_timer_if #(.CNT_W(CW), .N_PHASE(NP)) bus ();

    phase_timer #(
        .CNT_W  (CW),
        .N_PHASE(NP),
        .DUR0   (8'(D0)),
        .DUR1   (8'(D1)),
        .DUR2   (8'(D2))
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic       busy;
        logic [1:0] phase;
        logic [7:0] rem;
        logic       done;
        logic [2:0] exp;
    } snap_t;

    snap_t exp_q[$];
    int    ev_q[$];
    int    n_checks = 0;
    int    n_err    = 0;

    // Reference model: a phase of duration D lasts D+1 active cycles.
    bit m_run, m_auto;
    int m_phase, m_len, m_elapsed;
    int m_dur[NP];

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_run     = 1'b0;
        m_auto    = 1'b0;
        m_phase   = 0;
        m_len     = 0;
        m_elapsed = 0;
        m_dur     = '{D0, D1, D2};
    endtask

    task automatic model_step(bit st, int sp, bit au, bit hd, bit ab, bit we, int cph, int cdur);
        int    pulse;
        snap_t s;
        pulse = -1;
        if (ab) begin
            m_run = 1'b0;
        end else if (st && sp < NP) begin
            m_run     = 1'b1;
            m_phase   = sp;
            m_len     = m_dur[sp] + 1;
            m_elapsed = 0;
            m_auto    = au;
        end else if (m_run && !hd) begin
            if (m_elapsed + 1 < m_len) begin
                m_elapsed++;
            end else begin
                pulse = m_phase;
                if (m_auto) begin
                    m_phase   = (m_phase + 1) % NP;
                    m_len     = m_dur[m_phase] + 1;
                    m_elapsed = 0;
                end else begin
                    m_run = 1'b0;
                end
            end
        end
        if (we && cph < NP) m_dur[cph] = cdur;

        s.busy  = m_run;
        s.phase = 2'(m_phase);
        s.rem   = m_run ? 8'(m_len - 1 - m_elapsed) : 8'd0;
        s.done  = (pulse >= 0);
        s.exp   = (pulse >= 0) ? 3'(1 << pulse) : 3'd0;
        exp_q.push_back(s);
        if (pulse >= 0) ev_q.push_back(pulse);
    endtask

    task automatic drive_idle();
        bus.start       = 1'b0;
        bus.start_phase = '0;
        bus.auto        = 1'b0;
        bus.hold        = 1'b0;
        bus.abort       = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_phase   = '0;
        bus.cfg_dur     = '0;
    endtask

    task automatic tick(bit st = 0, int sp = 0, bit au = 0, bit hd = 0, bit ab = 0,
                        bit we = 0, int cph = 0, int cdur = 0);
        bus.start       = st;
        bus.start_phase = 2'(sp);
        bus.auto        = au;
        bus.hold        = hd;
        bus.abort       = ab;
        bus.cfg_we      = we;
        bus.cfg_phase   = 2'(cph);
        bus.cfg_dur     = 8'(cdur);
        model_step(st, sp, au, hd, ab, we, cph, cdur);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        #1;
        check("midrun_reset", 32'({bus.busy, bus.phase, bus.remaining, bus.phase_done, bus.expired}), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin : monitor
        snap_t got;
        snap_t want;
        int    ph;
        #1;
        got = {bus.busy, bus.phase, bus.remaining, bus.phase_done, bus.expired};
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("cycle_outputs", 32'(got), 32'(want));
        end
        if (bus.phase_done) begin
            if (ev_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL spurious_done at %0t: phase_done=1 expired=%0b, no expiry expected",
                         $time, bus.expired);
            end else begin
                ph = ev_q.pop_front();
                check("expired_onehot", 32'(bus.expired), 32'(1 << ph));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({bus.busy, bus.phase, bus.remaining, bus.phase_done, bus.expired}), 32'd0);
        rst_n = 1'b1;

        // Single shot on green.
        tick(.st(1), .sp(PH_GREEN));
        repeat (7) tick();

        // Auto mode through all phases and one wrap.
        tick(.st(1), .sp(PH_GREEN), .au(1));
        repeat (16) tick();
        tick(.ab(1));
        tick();

        // Hold for three cycles at remaining=2.
        tick(.st(1), .sp(PH_GREEN));
        repeat (2) tick();
        repeat (3) tick(.hd(1));
        repeat (5) tick();

        // Abort wins over start on the same edge; invalid start_phase is ignored.
        tick(.st(1), .sp(PH_RED));
        tick();
        tick(.st(1), .sp(PH_YELLOW), .ab(1));
        repeat (3) tick();
        tick(.st(1), .sp(3));
        repeat (3) tick();

        // Reprogram green while green runs; invalid cfg index is ignored.
        tick(.st(1), .sp(PH_GREEN), .au(1));
        tick(.we(1), .cph(PH_GREEN), .cdur(7));
        repeat (22) tick();
        tick(.we(1), .cph(3), .cdur(9));
        tick(.ab(1));
        tick(.st(1), .sp(PH_GREEN));
        repeat (9) tick();

        // Write and load of the same phase on one edge: load takes the old value.
        tick(.st(1), .sp(PH_YELLOW), .we(1), .cph(PH_YELLOW), .cdur(5));
        repeat (4) tick();
        tick(.st(1), .sp(PH_YELLOW));
        repeat (8) tick();

        // Start on the expiry edge overrides the auto advance and suppresses the pulse.
        tick(.we(1), .cph(PH_YELLOW), .cdur(1));
        tick(.st(1), .sp(PH_YELLOW), .au(1));
        tick();
        tick(.st(1), .sp(PH_RED));
        repeat (5) tick();

        // Reset mid-run after reprogramming green; defaults must return.
        tick(.we(1), .cph(PH_GREEN), .cdur(6));
        tick(.st(1), .sp(PH_GREEN));
        repeat (3) tick();
        do_reset();
        tick(.st(1), .sp(PH_GREEN));
        repeat (7) tick();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(7) == 0, $urandom_range(3), $urandom_range(1) == 1,
                 $urandom_range(4) == 0, $urandom_range(29) == 0, $urandom_range(9) == 0,
                 $urandom_range(3), $urandom_range(5));
        end

        tick(.ab(1));
        repeat (3) tick();
        drive_idle();
        @(negedge clk);
        check("events_left", 32'(ev_q.size()), 32'd0);
        check("snapshots_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
